op_sram_acc: RTL and testbench

// - Parametrised single-port output/psum SRAM for the systolic array's OFIFO-to-SFU path.
// - Adds a lane-wise accumulate-write mode (mem[A] += D) and a read-valid flag to the plain read/write macro.
// - Lets the SFU accumulate partial sums across K-tiles without a separate read-add-write loop.
// - Sits between the OFIFO drain and the final output readout.

---
 rtl/op_sram_acc.sv | 97 +++++++++
 tb/tb_op_sram_acc.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/op_sram_acc.sv
// Single-port psum SRAM with lane-wise accumulate-write, 2-stage write pipeline and forwarding.
// Define OP_SRAM_ACC_SAT_EN for saturating lane sums; otherwise lane sums wrap.
module op_sram_acc #(
   parameter int DEPTH  = 16,
   parameter int LANES  = 8,
   parameter int LANE_W = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cen,
   input  logic                      wen,
   input  logic                      acc,
   input  logic [ADDR_W-1:0]         a,
   input  logic [LANES*LANE_W-1:0]   d,
   output logic [LANES*LANE_W-1:0]   q,
   output logic                      q_valid
);

   localparam int W = LANES * LANE_W;

   function automatic logic [LANE_W-1:0] lane_add(input logic [LANE_W-1:0] x,
                                                  input logic [LANE_W-1:0] y);
      logic [LANE_W-1:0] s;
      s = x + y;
`ifdef OP_SRAM_ACC_SAT_EN
      // Overflow only when both operands share a sign the result lacks.
      if ((x[LANE_W-1] == y[LANE_W-1]) && (s[LANE_W-1] != x[LANE_W-1]))
         s = x[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
`endif
      return s;
   endfunction

   function automatic logic [W-1:0] word_add(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < LANES; i++)
         r[i*LANE_W +: LANE_W] = lane_add(x[i*LANE_W +: LANE_W], y[i*LANE_W +: LANE_W]);
      return r;
   endfunction

   logic [W-1:0]      mem [DEPTH];
   logic              wr_valid;
   logic              wr_acc;
   logic [ADDR_W-1:0] wr_addr;
   logic [W-1:0]      wr_data;
   logic [W-1:0]      wr_old;
   logic [W-1:0]      wr_word;
   logic [W-1:0]      fetch_word;
   logic              in_range;
   logic              rd_req;
   logic              wr_req;

   assign in_range = ({1'b0, a} < (ADDR_W+1)'(DEPTH));
   assign rd_req   = !cen && wen;
   assign wr_req   = !cen && !wen;
   assign wr_word  = wr_acc ? word_add(wr_old, wr_data) : wr_data;

   // The word being committed this cycle is newer than the array copy.
   always_comb begin
      // NOTE: default first so every path assigns fetch_word and no latch is inferred.
      fetch_word = '0;
      if (wr_valid && (wr_addr == a))
         fetch_word = wr_word;
      else if (in_range)
         fetch_word = mem[a];
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_valid <= 1'b0;
         wr_acc   <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         wr_old   <= '0;
         q        <= '0;
         q_valid  <= 1'b0;
      end else begin
         wr_valid <= wr_req && in_range;
         wr_acc   <= acc;
         wr_addr  <= a;
         wr_data  <= d;
         wr_old   <= fetch_word;
         q_valid  <= rd_req;
         if (rd_req)
            q <= fetch_word;
      end
   end

   // NOTE: the array has no reset; clearing wr_valid is enough to abort a pending write.
   always_ff @(posedge clk) begin
      if (wr_valid)
         mem[wr_addr] <= wr_word;
   end

endmodule

// File: tb/tb_op_sram_acc.sv
// Directed self-checking bench for op_sram_acc, plus a short randomized phase against a program-order model.
// Expected accumulate values follow OP_SRAM_ACC_SAT_EN when it is defined for the build.
module tb_op_sram_acc;

   logic         clk;
   logic         rst_n;
   logic         cen;
   logic         wen;
   logic         acc;
   logic [3:0]   a;
   logic [127:0] d;
   logic [127:0] q;
   logic         q_valid;

   int total = 0;
   int bad   = 0;

   logic [127:0] exp_mem [16];
   logic [127:0] last_q;
   logic [127:0] w4, a4, e4, rnd;
   logic [3:0]   ra;

   op_sram_acc dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .wen(wen), .acc(acc),
      .a(a), .d(d), .q(q), .q_valid(q_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic do_op(input logic c, input logic w, input logic ac,
                        input logic [3:0] ad, input logic [127:0] dd);
      cen = c; wen = w; acc = ac; a = ad; d = dd;
      @(posedge clk);
      #1;
   endtask

   task automatic op_wr(input logic [3:0] ad, input logic [127:0] dd); do_op(1'b0, 1'b0, 1'b0, ad, dd); endtask
   task automatic op_acc(input logic [3:0] ad, input logic [127:0] dd); do_op(1'b0, 1'b0, 1'b1, ad, dd); endtask
   task automatic op_rd(input logic [3:0] ad); do_op(1'b0, 1'b1, 1'b0, ad, '0); endtask
   task automatic op_idle(); do_op(1'b1, 1'b1, 1'b0, 4'd0, '0); endtask

   function automatic logic [127:0] splat(input logic [15:0] v);
      logic [127:0] r;
      for (int i = 0; i < 8; i++) r[i*16 +: 16] = v;
      return r;
   endfunction

   function automatic logic [127:0] model_acc(input logic [127:0] o, input logic [127:0] x);
      logic [127:0] r;
      int s;
      for (int i = 0; i < 8; i++) begin
         s = int'($signed(o[i*16 +: 16])) + int'($signed(x[i*16 +: 16]));
`ifdef OP_SRAM_ACC_SAT_EN
         if (s > 32767)  s = 32767;
         if (s < -32768) s = -32768;
`endif
         r[i*16 +: 16] = s[15:0];
      end
      return r;
   endfunction

   initial begin
      logic [127:0] lanes18;
      for (int i = 0; i < 8; i++) lanes18[i*16 +: 16] = 16'(i + 1);

      rst_n = 1'b0; cen = 1'b1; wen = 1'b1; acc = 1'b0; a = '0; d = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_q", q, '0);
      check("reset_q_valid", {127'd0, q_valid}, 128'd1 - 128'd1);
      rst_n = 1'b1;

      // Reset aborts an in-flight write
      op_wr(4'd7, splat(16'h1111));
      op_rd(4'd7);
      check("pre_reset_rd", q, splat(16'h1111));
      op_wr(4'd7, splat(16'h2222));
      rst_n = 1'b0;
      cen = 1'b1;
      #1;
      check("async_reset_q", q, '0);
      check("async_reset_q_valid", {127'd0, q_valid}, '0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      op_rd(4'd7);
      check("aborted_write_rd", q, splat(16'h1111));
      check("aborted_write_q_valid", {127'd0, q_valid}, 128'd1);

      // Overwrite then read, then hold
      op_wr(4'd3, lanes18);
      op_rd(4'd3);
      check("ovw_rd", q, lanes18);
      check("ovw_q_valid", {127'd0, q_valid}, 128'd1);
      op_idle();
      check("hold_q", q, lanes18);
      check("hold_q_valid", {127'd0, q_valid}, '0);

      // Disabled write must not land
      do_op(1'b1, 1'b0, 1'b0, 4'd3, splat(16'hFFFF));
      op_rd(4'd3);
      check("cen_high_write_ignored", q, lanes18);

      // Accumulate chain through forwarding
      op_wr(4'd5, splat(16'd10));
      op_acc(4'd5, splat(16'd7));
      op_acc(4'd5, splat(16'd7));
      op_acc(4'd5, splat(16'd7));
      op_rd(4'd5);
      check("acc_chain", q, splat(16'd31));

      // Lane isolation and overflow handling
      w4 = '0; a4 = '0; e4 = '0;
      w4[15:0] = 16'h7FFF; a4[15:0] = 16'h0001;
      w4[31:16] = 16'hFFFF; a4[31:16] = 16'h0001;
      w4[47:32] = 16'h8000; a4[47:32] = 16'hFFFF;
      for (int i = 3; i < 8; i++) w4[i*16 +: 16] = 16'(16'h0100 + i);
`ifdef OP_SRAM_ACC_SAT_EN
      e4[15:0] = 16'h7FFF; e4[47:32] = 16'h8000;
`else
      e4[15:0] = 16'h8000; e4[47:32] = 16'h7FFF;
`endif
      e4[31:16] = 16'h0000;
      for (int i = 3; i < 8; i++) e4[i*16 +: 16] = 16'(16'h0100 + i);
      op_wr(4'd2, w4);
      op_idle();
      op_acc(4'd2, a4);
      op_idle();
      op_rd(4'd2);
      check("lane_isolation", q, e4);

      // Interleaved addresses from zeroed words
      op_wr(4'd1, '0);
      op_wr(4'd2, '0);
      op_acc(4'd1, splat(16'd4));
      op_acc(4'd2, splat(16'd9));
      op_rd(4'd1);
      check("interleave_rd1_first", q, splat(16'd4));
      op_acc(4'd1, splat(16'd4));
      op_rd(4'd1);
      check("interleave_rd1_second", q, splat(16'd8));
      op_rd(4'd2);
      check("interleave_rd2", q, splat(16'd9));

      // Randomized mixed traffic against a program-order model
      for (int i = 0; i < 16; i++) begin
         rnd = {$urandom, $urandom, $urandom, $urandom};
         op_wr(4'(i), rnd);
         exp_mem[i] = rnd;
      end
      last_q = q;
      for (int n = 0; n < 400; n++) begin
         ra  = 4'($urandom_range(0, 15));
         rnd = {$urandom, $urandom, $urandom, $urandom};
         case ($urandom_range(0, 3))
            0: begin
               op_rd(ra);
               check("rnd_rd", q, exp_mem[ra]);
               check("rnd_rd_valid", {127'd0, q_valid}, 128'd1);
               last_q = exp_mem[ra];
            end
            1: begin
               op_wr(ra, rnd);
               exp_mem[ra] = rnd;
               check("rnd_wr_hold", q, last_q);
            end
            2: begin
               op_acc(ra, rnd);
               exp_mem[ra] = model_acc(exp_mem[ra], rnd);
               check("rnd_acc_hold", q, last_q);
            end
            default: begin
               op_idle();
               check("rnd_idle_valid", {127'd0, q_valid}, '0);
            end
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
